// File: rtl/lcd_line_fetch.sv
// LCD line fetcher: streams 41 VRAM bytes of one scrolled line into a write bank,
// then serves 2-bit palette indices per pixel column from a double-buffered display bank.
module lcd_line_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        line_start,
  input  logic [7:0]  line_num,
  input  logic [7:0]  lcd_xscroll,
  input  logic [7:0]  lcd_yscroll,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  input  logic [7:0]  px_x,
  output logic [1:0]  px_idx,
  output logic        busy,
  output logic        done
);
  localparam int unsigned NBYTES = 41;
  localparam logic [5:0]  LAST   = 6'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state_q, state_d;

  logic [12:0] rowbase_q, rowbase_d;
  logic [5:0]  col0_q;
  logic [5:0]  idx_q;
  logic [1:0]  xs_wr_q, xs_disp_q;
  logic        bsel_q, ready_q, done_q;
  logic        rd_vld_q;
  logic [5:0]  rd_idx_q;
  logic [1:0]  px_idx_q;
  logic [7:0]  bank_q [2][NBYTES];

  logic [8:0]  row_sum, row_w;
  logic [6:0]  col_sum, col_w;
  logic [7:0]  px_p, px_byte;
  logic [5:0]  px_sel;

  // Row wraps over a 170-row map, column over a 48-byte row.
  always_comb begin
    row_sum   = {1'b0, line_num} + {1'b0, lcd_yscroll};
    row_w     = (row_sum >= 9'd170) ? row_sum - 9'd170 : row_sum;
    rowbase_d = {4'd0, row_w} * 13'd48;
    col_sum   = {1'b0, col0_q} + {1'b0, idx_q};
    col_w     = (col_sum >= 7'd48) ? col_sum - 7'd48 : col_sum;
  end

  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        FETCH:   if (idx_q == LAST) state_d = DRAIN;
        DRAIN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign vram_rd   = (state_q == FETCH);
  assign vram_addr = vram_rd ? rowbase_q + {6'd0, col_w} : 13'd0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign px_idx    = px_idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rowbase_q <= '0;
      col0_q    <= '0;
      xs_wr_q   <= '0;
      xs_disp_q <= '0;
      bsel_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == DRAIN) && !line_start;
      // A restart drops the read still in flight from the aborted fetch.
      rd_vld_q <= vram_rd && !line_start;
      rd_idx_q <= idx_q;
      if (line_start) begin
        rowbase_q <= rowbase_d;
        col0_q    <= lcd_xscroll[7:2];
        xs_wr_q   <= lcd_xscroll[1:0];
        idx_q     <= '0;
        if (ready_q) begin
          bsel_q    <= ~bsel_q;
          xs_disp_q <= xs_wr_q;
          ready_q   <= 1'b0;
        end
      end else begin
        if (state_q == FETCH) idx_q <= idx_q + 6'd1;
        if (state_q == DRAIN) ready_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rd_vld_q) bank_q[bsel_q][rd_idx_q] <= vram_data;
  end

  // Pixel path reads the bank not being written; fine scroll shifts into the next byte.
  always_comb begin
    px_p    = px_x + {6'd0, xs_disp_q};
    px_sel  = (px_p[7:2] > LAST) ? LAST : px_p[7:2];
    px_byte = bank_q[~bsel_q][px_sel];
  end

  always_ff @(posedge clk) begin
    if (reset)                       px_idx_q <= 2'd0;
    else if (ce && px_x <= 8'd159)   px_idx_q <= px_byte[{px_p[1:0], 1'b0} +: 2];
    else                             px_idx_q <= 2'd0;
  end
endmodule

// File: tb/tb_lcd_line_fetch.sv
// Bench for lcd_line_fetch: directed scenarios plus random traffic against a line-level model.
module tb_lcd_line_fetch;
  logic        clk = 1'b0;
  logic        reset, ce, line_start;
  logic [7:0]  line_num, lcd_xscroll, lcd_yscroll, vram_data, px_x;
  logic [12:0] vram_addr;
  logic        vram_rd, busy, done;
  logic [1:0]  px_idx;

  always #5 clk = ~clk;

  lcd_line_fetch dut (
    .clk(clk), .reset(reset), .ce(ce), .line_start(line_start),
    .line_num(line_num), .lcd_xscroll(lcd_xscroll), .lcd_yscroll(lcd_yscroll),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .px_x(px_x), .px_idx(px_idx), .busy(busy), .done(done)
  );

  logic [7:0] vmem [0:8191];
  always @(posedge clk) vram_data <= vmem[vram_addr];

  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Line-level model: a fetch is "k cycles old"; completion snapshots the whole line.
  bit         m_act, m_ready, m_done, m_dvalid, m_pxk;
  int         m_k, m_row, m_col0, m_xs, m_wxs, m_dxs;
  logic [7:0] m_wline [41];
  logic [7:0] m_dline [41];
  int         m_px;

  function automatic int exp_addr(input int k);
    return m_row * 48 + (m_col0 + k - 1) % 48;
  endfunction

  task automatic model_step();
    int p;
    if (reset) begin
      m_act = 0; m_ready = 0; m_done = 0; m_px = 0; m_pxk = 1; m_dxs = 0; m_dvalid = 0;
      return;
    end
    if (!ce || px_x > 8'd159) begin
      m_px = 0; m_pxk = 1;
    end else begin
      p     = (int'(px_x) + m_dxs) % 256;
      m_px  = (int'(m_dline[p / 4]) >> (2 * (p % 4))) & 3;
      m_pxk = m_dvalid;
    end
    m_done = 0;
    if (line_start) begin
      if (m_ready) begin
        m_dline = m_wline; m_dxs = m_wxs; m_dvalid = 1; m_ready = 0;
      end
      m_row  = (int'(line_num) + int'(lcd_yscroll)) % 170;
      m_col0 = int'(lcd_xscroll) / 4;
      m_xs   = int'(lcd_xscroll) % 4;
      m_act  = 1; m_k = 1;
    end else if (m_act) begin
      if (m_k == 42) begin
        for (int i = 0; i < 41; i++) m_wline[i] = vmem[m_row * 48 + (m_col0 + i) % 48];
        m_wxs = m_xs; m_ready = 1; m_done = 1; m_act = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", int'(busy), int'(m_act));
      chk("vram_rd", int'(vram_rd), int'(m_act && m_k <= 41));
      chk("vram_addr", int'(vram_addr), (m_act && m_k <= 41) ? exp_addr(m_k) : 0);
      chk("done", int'(done), int'(m_done));
      if (m_pxk) chk("px_idx", int'(px_idx), m_px);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic start(input int ln, input int ys, input int xs);
    line_start = 1; line_num = 8'(ln); lcd_yscroll = 8'(ys); lcd_xscroll = 8'(xs);
    tick();
    line_start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 100) begin tick(); n++; end
    chk(nm, int'(done), 1);
  endtask

  initial begin
    int n, seen;
    reset = 1; ce = 1; line_start = 0; line_num = 0; lcd_xscroll = 0; lcd_yscroll = 0; px_x = 0;
    foreach (vmem[i]) vmem[i] = 8'($urandom);
    for (int i = 0; i < 41; i++) begin
      vmem[i]      = 8'(i);
      vmem[48 + i] = 8'h9C ^ 8'(i);
    end
    tick(); chk_on = 1; tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd", int'(vram_rd), 0);
    chk("rst_addr", int'(vram_addr), 0);
    chk("rst_px", int'(px_idx), 0);
    reset = 0; tick();

    // Straight line 0 fetch: addresses 0..40, busy through the drain, done 43 cycles on.
    start(0, 0, 0);
    chk("l0_addr_first", int'(vram_addr), 0);
    chk("l0_busy_first", int'(busy), 1);
    for (int i = 1; i <= 40; i++) tick();
    chk("l0_addr_last", int'(vram_addr), 40);
    tick();
    chk("l0_drain_rd", int'(vram_rd), 0);
    chk("l0_drain_busy", int'(busy), 1);
    tick();
    chk("l0_done", int'(done), 1);
    chk("l0_done_busy", int'(busy), 0);

    // Swap in line 0 (byte i = i) and read pixels from it.
    start(0, 0, 0);
    px_x = 5; tick(); chk("px5", int'(px_idx), 0);
    px_x = 4; tick(); chk("px4", int'(px_idx), 1);
    px_x = 8; tick(); chk("px8", int'(px_idx), 2);
    wait_done("l0b_done");

    // Line 1 with fine scroll 3, then swap it into display.
    start(1, 0, 3);
    wait_done("l1_done");
    start(2, 0, 0);
    px_x = 0;   tick(); chk("fs3_px0", int'(px_idx), 2);
    px_x = 159; tick(); chk("fs3_px159", int'(px_idx), 3);
    ce = 0; px_x = 0; tick(); chk("ce_off", int'(px_idx), 0);
    ce = 1; px_x = 200; tick(); chk("px_oob", int'(px_idx), 0);
    wait_done("l2_done");

    // Vertical wrap and column wrap.
    start(159, 20, 8'hB8);
    chk("wrap_a0", int'(vram_addr), 478); tick();
    chk("wrap_a1", int'(vram_addr), 479); tick();
    chk("wrap_a2", int'(vram_addr), 432); tick();
    chk("wrap_a3", int'(vram_addr), 433);
    wait_done("wrap_done");

    // Restart 20 cycles into a fetch.
    start(10, 0, 0);
    repeat (19) tick();
    start(20, 0, 0);
    chk("abort_addr", int'(vram_addr), 960);
    n = 1;
    while (!done && n < 60) begin tick(); n++; end
    chk("abort_done_lat", n, 43);

    // Reset in the middle of a fetch.
    start(5, 0, 0);
    repeat (9) tick();
    reset = 1; tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rd", int'(vram_rd), 0);
    reset = 0; seen = 0;
    repeat (50) begin tick(); if (done) seen = 1; end
    chk("midrst_no_done", seen, 0);

    for (int c = 0; c < 3000; c++) begin
      int ln;
      ln          = $urandom_range(0, 159);
      line_start  = ($urandom_range(0, 59) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      line_num    = 8'(ln);
      lcd_yscroll = 8'($urandom_range(0, (339 - ln) > 255 ? 255 : 339 - ln));
      lcd_xscroll = 8'($urandom_range(0, 191));
      ce          = ($urandom_range(0, 9) != 0);
      px_x        = 8'($urandom_range(0, 199));
      tick();
    end
    reset = 0; line_start = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
